// File: rtl/systolic_controller.sv
// Sequencing controller for the buffered systolic module: takes one job and an element
// stream, then drives load/swap/shift/accumulate so k_len vector pairs plus drain zeros flow through.
module systolic_controller #(
  parameter int DATA_WIDTH  = 8,
  parameter int MATRIX_SIZE = 8,
  parameter int ADDR_WIDTH  = $clog2(MATRIX_SIZE),
  parameter int K_WIDTH     = 16,
  parameter int DRAIN_LEN   = 2*MATRIX_SIZE-2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [K_WIDTH-1:0]    k_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_top_data,
  input  logic [DATA_WIDTH-1:0] in_left_data,
  output logic                  busy,
  output logic                  done,
  output logic                  acc_rst,
  output logic                  acc_en,
  output logic                  shift_en,
  output logic                  buffer_rst_top,
  output logic                  buffer_rst_left,
  output logic                  load_en_top,
  output logic                  load_en_left,
  output logic                  swap_buffers_top,
  output logic                  swap_buffers_left,
  output logic [ADDR_WIDTH-1:0] addr_top,
  output logic [ADDR_WIDTH-1:0] addr_left,
  output logic [DATA_WIDTH-1:0] data_in_top,
  output logic [DATA_WIDTH-1:0] data_in_left
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] SWAP  = 3'd3;
  localparam logic [2:0] FEED  = 3'd4;
  localparam logic [2:0] ZERO  = 3'd5;
  localparam logic [2:0] DRAIN = 3'd6;
  localparam logic [2:0] DONE  = 3'd7;

  // A zero-length drain never enters DRAIN, so the counter keeps a minimum width of one bit.
  localparam int DRAIN_CW = (DRAIN_LEN > 0) ? $clog2(DRAIN_LEN + 1) : 1;
  localparam logic [ADDR_WIDTH-1:0] ELEM_LAST  = ADDR_WIDTH'(MATRIX_SIZE - 1);
  localparam logic [DRAIN_CW-1:0]   DRAIN_LAST = DRAIN_CW'(DRAIN_LEN - 1);

  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic [K_WIDTH-1:0]    k_len_q;
  logic [K_WIDTH-1:0]    k_cnt;
  logic [ADDR_WIDTH-1:0] elem_cnt;
  logic [DRAIN_CW-1:0]   drain_cnt;
  logic                  beat;
  logic                  last_vec;

  assign beat     = in_valid & in_ready;
  assign last_vec = (k_cnt == k_len_q - K_WIDTH'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CLEAR;
      CLEAR:   state_nxt = (k_len_q == '0) ? DONE : LOAD;
      LOAD:    if (beat && (elem_cnt == ELEM_LAST)) state_nxt = SWAP;
      SWAP:    state_nxt = FEED;
      FEED:    state_nxt = last_vec ? ZERO : LOAD;
      ZERO:    state_nxt = (DRAIN_LEN == 0) ? DONE : DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      k_len_q   <= '0;
      k_cnt     <= '0;
      elem_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            k_len_q  <= k_len;
            k_cnt    <= '0;
            elem_cnt <= '0;
          end
        end
        LOAD: begin
          if (beat) elem_cnt <= (elem_cnt == ELEM_LAST) ? '0 : elem_cnt + ADDR_WIDTH'(1);
        end
        // k_cnt stops at k_len-1, so the largest k_len never wraps it.
        FEED: begin
          if (!last_vec) k_cnt <= k_cnt + K_WIDTH'(1);
        end
        DRAIN: begin
          drain_cnt <= (drain_cnt == DRAIN_LAST) ? '0 : drain_cnt + DRAIN_CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy              = (state != IDLE);
  assign done              = (state == DONE);
  assign in_ready          = (state == LOAD);
  assign acc_rst           = (state == CLEAR);
  assign buffer_rst_top    = (state == CLEAR) || (state == ZERO);
  assign buffer_rst_left   = (state == CLEAR) || (state == ZERO);
  assign swap_buffers_top  = (state == SWAP);
  assign swap_buffers_left = (state == SWAP);
  assign shift_en          = (state == FEED) || (state == DRAIN);
  assign acc_en            = (state == FEED) || (state == DRAIN);

  // Data is forced to zero outside LOAD so every output stays quiet while idle.
  assign load_en_top  = beat;
  assign load_en_left = beat;
  assign addr_top     = elem_cnt;
  assign addr_left    = elem_cnt;
  assign data_in_top  = in_ready ? in_top_data  : '0;
  assign data_in_left = in_ready ? in_left_data : '0;

endmodule

// File: tb/tb_systolic_controller.sv
// Scoreboard bench for systolic_controller: jobs are planned from the cycle rules,
// expected beats and job summaries are queued, and a negedge monitor checks them.
module tb_systolic_controller;

  localparam int DW = 8;
  localparam int N  = 8;
  localparam int AW = 3;
  localparam int KW = 16;
  localparam int DL = 2*N-2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_top_data = '0;
  logic [DW-1:0] in_left_data = '0;
  logic          in_ready, busy, done, acc_rst, acc_en, shift_en;
  logic          buffer_rst_top, buffer_rst_left, load_en_top, load_en_left;
  logic          swap_buffers_top, swap_buffers_left;
  logic [AW-1:0] addr_top, addr_left;
  logic [DW-1:0] data_in_top, data_in_left;

  systolic_controller #(
    .DATA_WIDTH(DW), .MATRIX_SIZE(N), .ADDR_WIDTH(AW), .K_WIDTH(KW), .DRAIN_LEN(DL)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_top_data(in_top_data), .in_left_data(in_left_data),
    .busy(busy), .done(done), .acc_rst(acc_rst), .acc_en(acc_en), .shift_en(shift_en),
    .buffer_rst_top(buffer_rst_top), .buffer_rst_left(buffer_rst_left),
    .load_en_top(load_en_top), .load_en_left(load_en_left),
    .swap_buffers_top(swap_buffers_top), .swap_buffers_left(swap_buffers_left),
    .addr_top(addr_top), .addr_left(addr_left),
    .data_in_top(data_in_top), .data_in_left(data_in_left)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int done_cyc;
    int shifts;
    int swaps;
    int acc_rsts;
    int buf_rsts;
    int first_swap;
  } job_t;

  typedef struct {
    int            addr;
    logic [DW-1:0] top;
    logic [DW-1:0] left;
  } beat_t;

  job_t  exp_jobs[$];
  beat_t exp_beats[$];

  task automatic compare(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic failEvent(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got event expected none (cycle %0d)", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    in_valid     = 1'($urandom);
    in_top_data  = DW'($urandom);
    in_left_data = DW'($urandom);
  endtask

  task automatic checkOutput();
    logic [33:0] outs;
    outs = {in_ready, busy, done, acc_rst, acc_en, shift_en, buffer_rst_top, buffer_rst_left,
            load_en_top, load_en_left, swap_buffers_top, swap_buffers_left,
            addr_top, addr_left, data_in_top, data_in_left};
    compare("outputs_quiet", longint'(outs), 0);
  endtask

  task automatic idleCycles(input int n);
    start = 1'b0;
    repeat (n) begin
      noise();
      tick();
    end
  endtask

  // Must be entered one step after a rising edge with the controller idle; that cycle is cycle 0.
  task automatic applyStimulus(input int k, input int gap_mode, input bit seq_data, input bit abort_in_drain);
    int   gaps[$];
    int   total;
    int   first_gap;
    int   c0;
    int   idx;
    job_t j;
    beat_t b;
    total = 0;
    first_gap = 0;
    for (int i = 0; i < k*N; i++) begin
      int g;
      g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
      gaps.push_back(g);
      total += g;
      if (i < N) first_gap += g;
    end
    c0 = cyc;
    j.done_cyc   = (k == 0) ? c0 + 2 : c0 + 3 + k*(N+2) + total + DL;
    j.shifts     = (k == 0) ? 0 : k + DL;
    j.swaps      = k;
    j.acc_rsts   = 1;
    j.buf_rsts   = (k == 0) ? 1 : 2;
    j.first_swap = (k == 0) ? -1 : c0 + 2 + N + first_gap;
    exp_jobs.push_back(j);

    noise();
    start = 1'b1;
    k_len = KW'(k);
    tick();
    noise();
    start = 1'($urandom);
    k_len = KW'($urandom);
    tick();

    idx = 0;
    for (int v = 0; v < k; v++) begin
      for (int e = 0; e < N; e++) begin
        repeat (gaps[idx]) begin
          noise();
          in_valid = 1'b0;
          start = 1'($urandom);
          tick();
        end
        idx++;
        in_valid     = 1'b1;
        in_top_data  = seq_data ? DW'(e + 1) : DW'($urandom);
        in_left_data = seq_data ? DW'(e + 1) : DW'($urandom);
        b.addr = e;
        b.top  = in_top_data;
        b.left = in_left_data;
        exp_beats.push_back(b);
        start = 1'($urandom);
        tick();
      end
      repeat (2) begin
        noise();
        start = 1'($urandom);
        tick();
      end
    end

    if (k > 0) begin
      for (int d = 0; d < 1 + DL; d++) begin
        if (abort_in_drain && d == 4) begin
          rst = 1'b0;
          in_valid = 1'b1;
          start = 1'b0;
          #1;
          exp_jobs.delete();
          exp_beats.delete();
          checkOutput();
          tick();
          checkOutput();
          rst = 1'b1;
          in_valid = 1'b0;
          return;
        end
        noise();
        start = 1'($urandom);
        tick();
      end
    end

    noise();
    start = 1'($urandom);
    tick();
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  int    n_shift = 0;
  int    n_swap = 0;
  int    n_accrst = 0;
  int    n_bufrst = 0;
  int    first_swap = -1;
  job_t  mj;
  beat_t mb;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        n_shift = 0; n_swap = 0; n_accrst = 0; n_bufrst = 0; first_swap = -1;
        continue;
      end
      if (shift_en) n_shift++;
      if (swap_buffers_top) n_swap++;
      if (acc_rst) n_accrst++;
      if (buffer_rst_top) n_bufrst++;
      if (swap_buffers_top && first_swap < 0) first_swap = cyc;
      if (shift_en || acc_en) compare("acc_en_with_shift", acc_en, shift_en);
      if (swap_buffers_top || swap_buffers_left) compare("swap_pair", swap_buffers_left, swap_buffers_top);
      if (buffer_rst_top || buffer_rst_left) compare("buf_rst_pair", buffer_rst_left, buffer_rst_top);
      if (load_en_top || load_en_left) begin
        compare("load_en_pair", load_en_left, load_en_top);
        if (exp_beats.size() == 0) failEvent("unexpected_write");
        else begin
          mb = exp_beats.pop_front();
          compare("addr_top", addr_top, mb.addr);
          compare("addr_left", addr_left, mb.addr);
          compare("data_in_top", data_in_top, mb.top);
          compare("data_in_left", data_in_left, mb.left);
        end
      end
      if (done) begin
        if (exp_jobs.size() == 0) failEvent("unexpected_done");
        else begin
          mj = exp_jobs.pop_front();
          compare("done_cycle", cyc, mj.done_cyc);
          compare("shift_count", n_shift, mj.shifts);
          compare("swap_count", n_swap, mj.swaps);
          compare("acc_rst_count", n_accrst, mj.acc_rsts);
          compare("buf_rst_count", n_bufrst, mj.buf_rsts);
          compare("first_swap_cycle", first_swap, mj.first_swap);
          compare("busy_at_done", busy, 1);
        end
        n_shift = 0; n_swap = 0; n_accrst = 0; n_bufrst = 0; first_swap = -1;
      end
    end
  end

  initial begin
    rst = 1'b0;
    in_valid = 1'b1;
    in_top_data = 8'hA5;
    in_left_data = 8'h5A;
    repeat (3) begin
      tick();
      checkOutput();
    end
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (5) begin
      tick();
      checkOutput();
    end

    $display("[TB] single vector");
    applyStimulus(1, 0, 1'b1, 1'b0);
    idleCycles(1);
    $display("[TB] full 8x8 job");
    applyStimulus(8, 0, 1'b0, 1'b0);
    $display("[TB] backpressure");
    applyStimulus(2, 1, 1'b0, 1'b0);
    $display("[TB] zero length then busy starts");
    applyStimulus(0, 0, 1'b0, 1'b0);
    applyStimulus(3, 2, 1'b0, 1'b0);
    $display("[TB] reset mid-job");
    idleCycles(2);
    applyStimulus(2, 0, 1'b0, 1'b1);
    repeat (5) begin
      tick();
      checkOutput();
    end
    applyStimulus(1, 0, 1'b0, 1'b0);
    $display("[TB] random jobs");
    for (int r = 0; r < 6; r++) begin
      idleCycles($urandom_range(0, 2));
      applyStimulus($urandom_range(1, 4), 2, 1'b0, 1'b0);
    end

    for (int w = 0; w < 40 && exp_jobs.size() > 0; w++) tick();
    compare("jobs_pending", exp_jobs.size(), 0);
    compare("beats_pending", exp_beats.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
